// File: rtl/pixel_scaler_stream_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pixel_scaler_stream_if
// Bundles the coordinate stream, the source-buffer read bus and the scaled
// pixel output of pixel_scaler_stream.
//   display_x/y, display_valid : raster coordinate stream into the scaler
//   buf_rd_en/x/y              : buffer read strobe and source address
//   buf_rd_data                : buffer data, returned BUF_LAT cycles later
//   scaled_pixel/valid         : scaled output pixel
// Modports: master = stream source / buffer owner, slave = the scaler.
// -----------------------------------------------------------------------------
interface pixel_scaler_stream_if #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 1
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [10:0]      display_x;
    logic [10:0]      display_y;
    logic             display_valid;
    logic             buf_rd_en;
    logic [XW-1:0]    buf_rd_x;
    logic [YW-1:0]    buf_rd_y;
    logic [PIX_W-1:0] buf_rd_data;
    logic [PIX_W-1:0] scaled_pixel;
    logic             scaled_valid;

    modport master (
        output display_x, display_y, display_valid, buf_rd_data,
        input  buf_rd_en, buf_rd_x, buf_rd_y, scaled_pixel, scaled_valid
    );

    modport slave (
        input  display_x, display_y, display_valid, buf_rd_data,
        output buf_rd_en, buf_rd_x, buf_rd_y, scaled_pixel, scaled_valid
    );
endinterface

// File: rtl/pixel_scaler_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pixel_scaler_stream
// Nearest-neighbour integer upscaler for the right-half display pane. A
// raster-ordered coordinate stream is mapped onto an IMG_W x IMG_H source
// buffer magnified by SCALE and placed at (X_OFFSET, Y_OFFSET). Source
// indices come from phase/index counters, so no divider is needed.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : coordinate stream, buffer read bus, scaled output
//   border_en         : draw a BORDER_W frame around the image
//   grid_en           : draw cell-boundary grid lines
//   pix_invert        : invert image pixels
//   err_clr           : clear the sticky order_err flag
//   order_err         : sticky raster-order violation
// Output latency is BUF_LAT+1 cycles from the coordinate sampling edge.
// -----------------------------------------------------------------------------
module pixel_scaler_stream #(
    parameter int SCALE    = 10,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int PIX_W    = 1,
    parameter int X_OFFSET = 116,
    parameter int Y_OFFSET = 244,
    parameter int BUF_LAT  = 1,
    parameter int BORDER_W = 2,
    parameter logic [PIX_W-1:0] BORDER_COLOR = '1,
    parameter logic [PIX_W-1:0] GRID_COLOR   = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_scaler_stream_if.slave bus,
    input  logic                 border_en,
    input  logic                 grid_en,
    input  logic                 pix_invert,
    input  logic                 err_clr,
    output logic                 order_err
);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int PW    = $clog2(SCALE);
    localparam int X_END = X_OFFSET + SCALE * IMG_W;
    localparam int Y_END = Y_OFFSET + SCALE * IMG_H;

    logic [XW-1:0] src_x, src_x_n;
    logic [YW-1:0] src_y, src_y_n;
    logic [PW-1:0] phase_x, phase_x_n;
    logic [PW-1:0] phase_y, phase_y_n;
    logic [10:0]   prev_x, prev_y;
    // Set by the first frame start after reset; until then image pixels are
    // not fetched, so a mid-frame reset yields dark output, never misaligned.
    logic          synced;

    int   dx, dy;
    logic in_img_rect, in_brd_rect, frame_start, line_start;
    logic act, brd_hit, on_grid, err_hit;

    // Side-band flags, stage k is k+1 cycles after the sampling edge
    logic [BUF_LAT:0] img_p, brd_p, grid_p, inv_p;

    function automatic logic [PIX_W:0] select_pixel(
        input logic brd, input logic img, input logic grid, input logic inv,
        input logic [PIX_W-1:0] data
    );
        if (brd)
            return {1'b1, BORDER_COLOR};
        else if (grid)
            return {1'b1, GRID_COLOR};
        else if (img)
            return {1'b1, data ^ {PIX_W{inv}}};
        else
            return '0;
    endfunction

    always_comb begin
        dx = {21'd0, bus.display_x};
        dy = {21'd0, bus.display_y};
        in_img_rect = (dx >= X_OFFSET) && (dx < X_END) && (dy >= Y_OFFSET) && (dy < Y_END);
        in_brd_rect = (dx >= X_OFFSET - BORDER_W) && (dx < X_END + BORDER_W) &&
                      (dy >= Y_OFFSET - BORDER_W) && (dy < Y_END + BORDER_W) && !in_img_rect;
        frame_start = (dx == X_OFFSET) && (dy == Y_OFFSET);
        line_start  = (dx == X_OFFSET) && (dy != Y_OFFSET);
        act         = bus.display_valid && in_img_rect && (synced || frame_start);
        brd_hit     = bus.display_valid && border_en && in_brd_rect;

        src_x_n   = src_x;
        src_y_n   = src_y;
        phase_x_n = phase_x;
        phase_y_n = phase_y;
        if (act) begin
            if (frame_start) begin
                src_x_n   = '0;
                src_y_n   = '0;
                phase_x_n = '0;
                phase_y_n = '0;
            end else if (line_start) begin
                src_x_n   = '0;
                phase_x_n = '0;
                if (phase_y == PW'(SCALE - 1)) begin
                    phase_y_n = '0;
                    src_y_n   = src_y + 1'b1;
                end else begin
                    phase_y_n = phase_y + 1'b1;
                end
            end else begin
                if (phase_x == PW'(SCALE - 1)) begin
                    phase_x_n = '0;
                    src_x_n   = src_x + 1'b1;
                end else begin
                    phase_x_n = phase_x + 1'b1;
                end
            end
        end

        on_grid = (phase_x_n == '0) || (phase_y_n == '0);
        err_hit = act && (dx != X_OFFSET) &&
                  ((bus.display_x != prev_x + 11'd1) || (bus.display_y != prev_y));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synced           <= 1'b0;
            src_x            <= '0;
            src_y            <= '0;
            phase_x          <= '0;
            phase_y          <= '0;
            prev_x           <= '0;
            prev_y           <= '0;
            order_err        <= 1'b0;
            bus.buf_rd_en    <= 1'b0;
            bus.buf_rd_x     <= '0;
            bus.buf_rd_y     <= '0;
            img_p            <= '0;
            brd_p            <= '0;
            grid_p           <= '0;
            inv_p            <= '0;
            bus.scaled_valid <= 1'b0;
            bus.scaled_pixel <= '0;
        end else begin
            // Stage p0: counters, read address, order check
            if (act && frame_start)
                synced <= 1'b1;
            src_x   <= src_x_n;
            src_y   <= src_y_n;
            phase_x <= phase_x_n;
            phase_y <= phase_y_n;
            if (act) begin
                prev_x       <= bus.display_x;
                prev_y       <= bus.display_y;
                bus.buf_rd_x <= src_x_n;
                bus.buf_rd_y <= src_y_n;
            end
            bus.buf_rd_en <= act;
            // A new violation wins over a simultaneous clear
            if (err_hit)
                order_err <= 1'b1;
            else if (err_clr)
                order_err <= 1'b0;

            // Stages p1..pBUF_LAT: side-band flags track the buffer latency
            img_p[0]  <= act;
            brd_p[0]  <= brd_hit;
            grid_p[0] <= act && grid_en && on_grid;
            inv_p[0]  <= pix_invert;
            for (int k = 1; k <= BUF_LAT; k++) begin
                img_p[k]  <= img_p[k-1];
                brd_p[k]  <= brd_p[k-1];
                grid_p[k] <= grid_p[k-1];
                inv_p[k]  <= inv_p[k-1];
            end

            // Output stage: border > grid > image > blank
            {bus.scaled_valid, bus.scaled_pixel} <= select_pixel(
                brd_p[BUF_LAT], img_p[BUF_LAT], grid_p[BUF_LAT], inv_p[BUF_LAT],
                bus.buf_rd_data);
        end
    end
endmodule

// File: tb/tb_pixel_scaler_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pixel_scaler_stream
// Directed bench for pixel_scaler_stream. Three instances (BUF_LAT 1, 0, 3)
// share one coordinate stream; each has a checkerboard buffer model with the
// matching read latency. Expected pixels come from a division-based model of
// the display-to-source mapping.
// -----------------------------------------------------------------------------
module tb_pixel_scaler_stream;
    localparam int XO = 116;
    localparam int YO = 244;
    localparam int SC = 10;
    localparam int XE = XO + SC * 28;
    localparam int YE = YO + SC * 28;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst;
    logic border_en, grid_en, pix_invert, err_clr;
    logic err0, err1, err3;

    always #5 clk = ~clk;

    pixel_scaler_stream_if if1 ();
    pixel_scaler_stream_if if0 ();
    pixel_scaler_stream_if if3 ();

    assign if0.display_x     = if1.display_x;
    assign if0.display_y     = if1.display_y;
    assign if0.display_valid = if1.display_valid;
    assign if3.display_x     = if1.display_x;
    assign if3.display_y     = if1.display_y;
    assign if3.display_valid = if1.display_valid;

    function automatic logic buf_pix(input logic [4:0] x, input logic [4:0] y);
        return x[0] ^ y[0];
    endfunction

    logic d1, d3a, d3b, d3c;
    always @(posedge clk) begin
        d1  <= buf_pix(if1.buf_rd_x, if1.buf_rd_y);
        d3a <= buf_pix(if3.buf_rd_x, if3.buf_rd_y);
        d3b <= d3a;
        d3c <= d3b;
    end
    assign if0.buf_rd_data = buf_pix(if0.buf_rd_x, if0.buf_rd_y);
    assign if1.buf_rd_data = d1;
    assign if3.buf_rd_data = d3c;

    pixel_scaler_stream #(.BUF_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .border_en(border_en), .grid_en(grid_en),
        .pix_invert(pix_invert), .err_clr(err_clr), .order_err(err1));
    pixel_scaler_stream #(.BUF_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .border_en(border_en), .grid_en(grid_en),
        .pix_invert(pix_invert), .err_clr(err_clr), .order_err(err0));
    pixel_scaler_stream #(.BUF_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave), .border_en(border_en), .grid_en(grid_en),
        .pix_invert(pix_invert), .err_clr(err_clr), .order_err(err3));

    int n_tests = 0;
    int n_fail  = 0;
    int cur_x, cur_y;
    logic chk_out;
    logic [1:0] hist [0:4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at (%0d,%0d): observed=%0h expected=%0h", tag, cur_x, cur_y, obs, exp);
        end
    endtask

    // Returns {valid, pixel} for a coordinate under the current mode inputs
    function automatic logic [1:0] model(input int x, input int y, input logic v);
        int sx, sy;
        if (!v) return 2'b00;
        if (x >= XO && x < XE && y >= YO && y < YE) begin
            if (grid_en && (((x - XO) % SC == 0) || ((y - YO) % SC == 0)))
                return 2'b11;
            sx = (x - XO) / SC;
            sy = (y - YO) / SC;
            return {1'b1, 1'(((sx ^ sy) & 1)) ^ pix_invert};
        end
        if (border_en && x >= XO - BW && x < XE + BW && y >= YO - BW && y < YE + BW)
            return 2'b11;
        return 2'b00;
    endfunction

    task automatic step(input int x, input int y, input logic v);
        logic [1:0] e;
        logic img;
        if1.display_x     = x[10:0];
        if1.display_y     = y[10:0];
        if1.display_valid = v;
        e   = model(x, y, v);
        img = v && x >= XO && x < XE && y >= YO && y < YE;
        @(posedge clk);
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = e;
        #1;
        cur_x = x;
        cur_y = y;
        if (chk_out) begin
            check("out_lat1", {if1.scaled_valid, if1.scaled_pixel}, hist[2]);
            check("out_lat0", {if0.scaled_valid, if0.scaled_pixel}, hist[1]);
            check("out_lat3", {if3.scaled_valid, if3.scaled_pixel}, hist[4]);
            check("rd_en", if1.buf_rd_en, img);
            if (img) begin
                check("rd_x", if1.buf_rd_x, (x - XO) / SC);
                check("rd_y", if1.buf_rd_y, (y - YO) / SC);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0);
    endtask

    task automatic row_full(input int y);
        for (int x = 110; x <= 400; x++) step(x, y, 1'b1);
    endtask

    // Only the border columns and the line start; keeps phase_y advancing
    task automatic row_sparse(input int y);
        int cols [7];
        cols = '{113, 114, 115, 116, 396, 397, 398};
        for (int i = 0; i < 7; i++) step(cols[i], y, 1'b1);
    endtask

    task automatic frame();
        for (int y = 242; y <= 247; y++) row_full(y);
        for (int y = 248; y <= 519; y++) row_sparse(y);
        for (int y = 520; y <= 526; y++) row_full(y);
    endtask

    initial begin
        rst = 1'b1;
        border_en = 1'b0; grid_en = 1'b0; pix_invert = 1'b0; err_clr = 1'b0;
        chk_out = 1'b0;
        cur_x = 0; cur_y = 0;
        for (int k = 0; k < 5; k++) hist[k] = 2'b00;
        if1.display_x = '0; if1.display_y = '0; if1.display_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_en", if1.buf_rd_en, 0);
        check("rst_valid", if1.scaled_valid, 0);
        check("rst_pixel", if1.scaled_pixel, 0);
        check("rst_err", err1, 0);
        check("rst_valid3", if3.scaled_valid, 0);
        rst = 1'b0;
        chk_out = 1'b1;
        idle(3);

        // Plain checkerboard
        frame();
        check("no_err_plain", err1, 0);

        // Inverted pixels, grid and border frame
        border_en = 1'b1; grid_en = 1'b1; pix_invert = 1'b1;
        frame();
        check("no_err_modes", err1, 0);

        // Bubbles on display_valid
        grid_en = 1'b0; pix_invert = 1'b0;
        for (int y = 244; y <= 245; y++)
            for (int x = 110; x <= 400; x++) begin
                while ($urandom_range(0, 1) == 1) step(x, y, 1'b0);
                step(x, y, 1'b1);
            end
        check("no_err_bubbles", err1, 0);

        // Raster-order error flag
        chk_out = 1'b0;
        for (int x = 116; x <= 150; x++) step(x, 244, 1'b1);
        check("err_none", err1, 0);
        step(160, 244, 1'b1);
        check("err_set", err1, 1);
        step(161, 244, 1'b1);
        check("err_sticky", err1, 1);
        err_clr = 1'b1; step(162, 244, 1'b1); err_clr = 1'b0;
        check("err_clr", err1, 0);
        step(163, 244, 1'b1);
        check("err_stays_clr", err1, 0);
        err_clr = 1'b1; step(170, 244, 1'b1); err_clr = 1'b0;
        check("err_clr_collide", err1, 1);
        err_clr = 1'b1; step(171, 244, 1'b1); err_clr = 1'b0;
        check("err_clr2", err1, 0);
        step(172, 250, 1'b1);
        check("err_y_jump", err1, 1);
        check("err_y_jump_lat0", err0, 1);

        // Asynchronous reset in the middle of a line
        for (int x = 116; x <= 200; x++) step(x, 244, 1'b1);
        check("pre_rst_rd_x", if1.buf_rd_x, 8);
        #2 rst = 1'b1;
        #1;
        check("arst_rd_en", if1.buf_rd_en, 0);
        check("arst_rd_x", if1.buf_rd_x, 0);
        check("arst_valid", if1.scaled_valid, 0);
        check("arst_pixel", if1.scaled_pixel, 0);
        check("arst_err", err1, 0);
        check("arst_valid0", if0.scaled_valid, 0);
        check("arst_err3", err3, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int x = 201; x <= 205; x++) step(x, 244, 1'b1);
        idle(5);

        // Resynchronisation at the next frame start, all three latencies
        chk_out = 1'b1;
        row_full(244);
        row_full(245);
        check("no_err_final", err1, 0);
        check("no_err_final3", err3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_scaler_stream.md
Name: pixel_scaler_stream

Overview:
- Parametrised nearest-neighbour upscaler for the right-half display pane. Maps a raster-ordered stream of display coordinates onto an IMG_W×IMG_H source buffer, magnified by an integer SCALE and placed at a fixed offset.
- Uses incremental phase/index counters instead of dividers.
- Adds a multi-bit pixel width, configurable buffer read latency, an optional border frame, a grid overlay, pixel inversion, and a sticky raster-order error flag.

Parameters:
- SCALE, 10: integer magnification, ≥2.
- IMG_W, 28: source width in pixels.
- IMG_H, 28: source height in pixels.
- PIX_W, 1: bits per pixel.
- X_OFFSET, 116: first display column of the image.
- Y_OFFSET, 244: first display row of the image.
- BUF_LAT, 1: buffer read latency in cycles (0..3).
- BORDER_W, 2: border thickness drawn outside the image, in display pixels (0 disables).
- BORDER_COLOR, all ones: border pixel value.
- GRID_COLOR, all ones: grid line value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- display_x  in  11  display column
- display_y  in  11  display row
- display_valid  in  1  coordinate valid
- border_en  in  1  enable border frame
- grid_en  in  1  enable cell-boundary grid
- pix_invert  in  1  invert image pixels
- err_clr  in  1  clear order_err
- buf_rd_en  out  1  buffer read strobe
- buf_rd_x  out  clog2(IMG_W)  source column
- buf_rd_y  out  clog2(IMG_H)  source row
- buf_rd_data  in  PIX_W  buffer data, BUF_LAT cycles after address
- scaled_pixel  out  PIX_W  output pixel
- scaled_valid  out  1  output pixel valid
- order_err  out  1  sticky raster-order violation

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, counters, and the pipeline. The reset is clk, rst; the reset is asynchronous and active-high.
- Area definitions:
  - Image area: X_OFFSET ≤ x < X_OFFSET+SCALE·IMG_W and Y_OFFSET ≤ y < Y_OFFSET+SCALE·IMG_H.
  - Border area: within BORDER_W pixels outside the image area on any side, including corners; active only when border_en=1.
- Counters: src_x, phase_x (0..SCALE-1), src_y, phase_y (0..SCALE-1). They advance only on display_valid cycles inside the image area.
  - Frame start (x=X_OFFSET, y=Y_OFFSET): src_y=phase_y=0, src_x=phase_x=0.
  - Line start (x=X_OFFSET, y>Y_OFFSET, in area): src_x=phase_x=0. phase_y increments; on wrap from SCALE-1 to 0, src_y increments.
  - Other in-area pixel: phase_x increments; on wrap, src_x increments.
  - The address used for a pixel is the post-update counter value. Example: x=X_OFFSET+SCALE addresses src_x=1.
- Read stage: at the sampling edge E of an in-image valid coordinate, buf_rd_en=1 and buf_rd_x/buf_rd_y are registered. Otherwise buf_rd_en=0 and the address holds.
- Side pipeline: in_img, in_border, on_grid (phase_x==0 or phase_y==0), and pix_invert are delayed BUF_LAT+1 stages, matched to the data.
- Output stage: registered at edge E+BUF_LAT+1 (latency BUF_LAT+1 from the input edge). Priority:
  1. border → BORDER_COLOR, valid=1
  2. image with grid_en and on_grid → GRID_COLOR, valid=1
  3. image → buf_rd_data XOR {PIX_W{inv}}, valid=1
  4. otherwise → pixel=0, valid=0
- display_valid=0 inserts a bubble. Counters hold and the output slot is invalid.
- order_err is set on an in-image valid cycle that is not a frame/line start, where:
  - display_x ≠ previous in-image x + 1, or
  - display_y ≠ previous in-image y.

  It stays set until err_clr or rst. err_clr and a simultaneous new error leave it set. Counters are not corrected on error; the next frame start resynchronises them.
- Mode inputs are sampled with the coordinate, so a mid-line change affects only later pixels.
- Reset mid-frame: outputs go to 0 immediately. Output is garbage-free but image output is dark until the next frame start, since counters stay at 0 and addresses restart at src 0.

Test Plan:
- Full raster 512×768 with defaults, buffer holding a checkerboard (src_x^src_y): every image pixel equals checker[(x-116)/10][(y-244)/10] and appears 2 cycles after input. Corner (395,523) reads src (27,27); 396 is invalid.
- Same stimulus with pix_invert=1 and grid_en=1: pixels with (x-116)%10==0 or (y-244)%10==0 output 1; all others are the inverted checker.
- border_en=1, BORDER_W=2: pixels at x=114,115 and x=396,397 within the rows 242..525 output 1 with valid=1; x=113 outputs valid=0.
- Random display_valid bubbles (50%) across a line: address sequence and outputs are identical to the bubble-free run, only time-shifted; no counter advance on bubbles.
- Jump x from 150 to 160 mid-line: order_err=1 and stays high. Assert err_clr → 0 the next cycle. err_clr together with a new jump → remains 1.
- Assert rst mid-line at x=200: all outputs 0 asynchronously. The next frame start produces correct addresses (116,244)→(0,0). Rerun with BUF_LAT=0 and 3: latency is 1 and 4 cycles respectively.
